// File: rtl/cpu_trace_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_trace_monitor: circular retire-trace buffer, drained oldest-first    |
// | over valid/ready. Optional macro TRACE_TRIGGER_EN adds PC trigger + POST.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_trace_monitor #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int REG_W     = 3,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       retire,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [DATA_W-1:0]          instr,
  input  logic                       wr_en,
  input  logic [REG_W-1:0]           wr_reg,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       arm,
  input  logic                       stop,
`ifdef TRACE_TRIGGER_EN
  input  logic [ADDR_W-1:0]          trig_pc,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic                       out_wr_en,
  output logic [REG_W-1:0]           out_wr_reg,
  output logic [DATA_W-1:0]          out_wr_data,
  output logic [TS_W-1:0]            out_ts,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W + 1 + REG_W + DATA_W + TS_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_r;
  logic [TS_W-1:0] ts;
  logic            ovf;
  logic [EW-1:0]   mem [DEPTH];

  logic            capturing;
  logic            do_wr;
  logic            pop;
  logic [PW-1:0]   rd_ptr;

`ifdef TRACE_TRIGGER_EN
  logic [CW-1:0]   post_cnt;
`endif

  assign capturing = (state == S_CAPTURE) || (state == S_POST);
  assign do_wr     = retire && capturing;
  // A full buffer gives count[PW-1:0]==0, so the oldest entry sits at wr_ptr.
  assign rd_ptr    = wr_ptr - count_r[PW-1:0];
  assign out_valid = (state == S_DRAIN) && (count_r != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != S_IDLE);
  assign count     = count_r;
  assign overflow  = ovf;

  assign {out_pc, out_instr, out_wr_en, out_wr_reg, out_wr_data, out_ts} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= {pc, instr, wr_en, wr_reg, wr_data, ts};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      count_r  <= '0;
      ts       <= '0;
      ovf      <= 1'b0;
`ifdef TRACE_TRIGGER_EN
      post_cnt <= '0;
`endif
    end else begin
      ts <= ts + 1'b1;

      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count_r == FULL) begin
          ovf <= 1'b1;
        end else begin
          count_r <= count_r + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (arm) begin
            state   <= S_CAPTURE;
            wr_ptr  <= '0;
            count_r <= '0;
            ovf     <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (stop) begin
            state <= S_DRAIN;
          end
`ifdef TRACE_TRIGGER_EN
          else if (retire && (pc == trig_pc)) begin
            if (POST_TRIG == 1) begin
              state <= S_DRAIN;
            end else begin
              state    <= S_POST;
              post_cnt <= CW'(POST_TRIG - 1);
            end
          end
`endif
        end
`ifdef TRACE_TRIGGER_EN
        S_POST: begin
          // post_cnt = entries still owed after the trigger; the capture that
          // exhausts it is the last one kept.
          if (stop) begin
            state <= S_DRAIN;
          end else if (retire) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt <= CW'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
`endif
        S_DRAIN: begin
          if (count_r == '0) begin
            state <= S_IDLE;
          end else if (pop) begin
            count_r <= count_r - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_trace_monitor: directed self-checking bench for cpu_trace_monitor |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retire = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] instr = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] trig_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        out_wr_en;
  logic [2:0]  out_wr_reg;
  logic [15:0] out_wr_data;
  logic [15:0] out_ts;
  logic        busy;
  logic [4:0]  count;
  logic        overflow;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [15:0] exp_ts [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  cpu_trace_monitor #(
    .ADDR_W(16), .DATA_W(16), .REG_W(3), .DEPTH(16), .TS_W(16), .POST_TRIG(3)
  ) dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .instr(instr),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .arm(arm), .stop(stop),
`ifdef TRACE_TRIGGER_EN
    .trig_pc(trig_pc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg),
    .out_wr_data(out_wr_data), .out_ts(out_ts), .busy(busy), .count(count),
    .overflow(overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_retire(input logic [15:0] p);
    retire  = 1'b1;
    pc      = p;
    instr   = p ^ 16'hA5A5;
    wr_data = p + 16'h1000;
    wr_en   = p[0];
    wr_reg  = p[2:0];
  endtask

  // arm, n retires pc=base+i, then stop (optionally in the same cycle as the last retire)
  task automatic run_capture(input int n, input logic [15:0] base, input bit stop_on_last);
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_retire(base + 16'(i));
      if (i < 32) exp_ts[i] = 16'(cyc);
      if (stop_on_last && i == n - 1) stop = 1'b1;
      step();
    end
    retire = 1'b0;
    if (!stop_on_last) begin
      stop = 1'b1;
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_state busy=%b count=%0d valid=%b ovf=%b required 0/0/0/0",
               busy, count, out_valid, overflow);
    else pass_cnt++;
  endtask

  task automatic test_idle_ignore();
    stop = 1'b1;
    drive_retire(16'h0042);
    step();
    stop = 1'b0;
    retire = 1'b0;
    step();
    total_cnt++;
    if (busy !== 1'b0 || count !== 5'd0)
      $display("FAIL idle_ignore busy=%b count=%0d required 0/0", busy, count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_capture(5, 16'h0000, 1'b0);
    total_cnt++;
    if (count !== 5'd5 || overflow !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_after_stop count=%0d ovf=%b busy=%b required 5/0/1",
               count, overflow, busy);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== (16'(i) ^ 16'hA5A5) ||
          out_wr_data !== 16'(i) + 16'h1000 || out_wr_en !== i[0] ||
          out_wr_reg !== 3'(i) || out_ts !== exp_ts[i])
        $display("FAIL basic_entry%0d valid=%b pc=%h instr=%h wd=%h we=%b wr=%0d ts=%h required pc=%h ts=%h",
                 i, out_valid, out_pc, out_instr, out_wr_data, out_wr_en, out_wr_reg, out_ts,
                 16'(i), exp_ts[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (out_valid !== 1'b0 || count !== 5'd0)
      $display("FAIL basic_empty valid=%b count=%0d required 0/0", out_valid, count);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL basic_idle busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    run_capture(20, 16'h0000, 1'b0);
    total_cnt++;
    if (overflow !== 1'b1 || count !== 5'd16)
      $display("FAIL ovf_flags ovf=%b count=%0d required 1/16", overflow, count);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 16'(4 + i))
        $display("FAIL ovf_entry%0d valid=%b pc=%h required 1/%h", i, out_valid, out_pc, 16'(4 + i));
      else pass_cnt++;
      step();
    end
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL ovf_idle busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int idx;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    idx = 0;
    run_capture(4, 16'h0020, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (idx == 4) break;
      out_ready = pat[c % 4];
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0020 + 16'(idx))
        $display("FAIL stall_c%0d valid=%b pc=%h required 1/%h", c, out_valid, out_pc,
                 16'h0020 + 16'(idx));
      else pass_cnt++;
      step();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (idx !== 4 || out_valid !== 1'b0)
      $display("FAIL stall_done popped=%0d valid=%b required 4/0", idx, out_valid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_stop_retire();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'h1; exp_pc[1] = 16'h2; exp_pc[2] = 16'h3; exp_pc[3] = 16'h7;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_retire(16'(i));
      step();
    end
    drive_retire(16'h0007);
    stop = 1'b1;
    step();
    stop = 1'b0;
    drive_retire(16'h0099);
    total_cnt++;
    if (count !== 5'd4)
      $display("FAIL stopret_count count=%0d required 4", count);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i])
        $display("FAIL stopret_entry%0d valid=%b pc=%h required 1/%h", i, out_valid, out_pc, exp_pc[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (out_valid !== 1'b0 || count !== 5'd0)
      $display("FAIL stopret_empty valid=%b count=%0d required 0/0", out_valid, count);
    else pass_cnt++;
    retire = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_zero_capture();
    arm = 1'b1;
    step();
    arm = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0)
      $display("FAIL zero_drain busy=%b valid=%b count=%0d required 1/0/0", busy, out_valid, count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL zero_idle busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    run_capture(3, 16'h0030, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || count !== 5'd3)
      $display("FAIL midrst_pre valid=%b count=%0d required 1/3", out_valid, count);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || count !== 5'd0 || busy !== 1'b0)
      $display("FAIL midrst_post valid=%b count=%0d busy=%b required 0/0/0", out_valid, count, busy);
    else pass_cnt++;
    step();
  endtask

`ifdef TRACE_TRIGGER_EN
  task automatic test_trigger();
    trig_pc = 16'h000A;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int p = 5; p <= 20; p++) begin
      drive_retire(16'(p));
      step();
    end
    retire = 1'b0;
    total_cnt++;
    if (count !== 5'd8 || busy !== 1'b1)
      $display("FAIL trig_count count=%0d busy=%b required 8/1", count, busy);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 16'(5 + i))
        $display("FAIL trig_entry%0d valid=%b pc=%h required 1/%h", i, out_valid, out_pc, 16'(5 + i));
      else pass_cnt++;
      step();
    end
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL trig_idle busy=%b required 0", busy);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_overflow();
    test_stall();
    test_stop_retire();
    test_zero_capture();
    test_reset_mid();
`ifdef TRACE_TRIGGER_EN
    test_trigger();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
